// File: rtl/state_dump_tx.sv
// state_dump_tx
//   Streams a snapshot of CPU architectural state on a valid/ready word stream.
//   The stream is one header word holding the free-running cycle count, then the
//   register file r0..r(NUM_REGS-1), then data memory m0..m(NUM_MEM-1).
//   freeze_o asks the CPU to stall so that the snapshot is coherent.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             dump request, only looked at while idle
//   busy_o, freeze_o    dump in progress (identical)
//   rf_addr_o/rf_data_i register file read port (combinational read)
//   dm_addr_o/dm_data_i data memory byte-address read port (combinational read)
//   dout_*              output word stream: valid/ready/data/tag/last
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no dump; waiting for start_i
// ST_REG   | loading register words r0..r(NUM_REGS-1)
// ST_MEM   | loading memory words m0..m(NUM_MEM-1)
// ST_DRAIN | final word loaded, waiting for it to be accepted
module state_dump_tx #(
   parameter int          DATA_W   = 32,
   parameter int          NUM_REGS = 32,
   parameter int          NUM_MEM  = 32,
   parameter logic [31:0] MEM_BASE = 32'h0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              freeze_o,
   output logic [4:0]        rf_addr_o,
   input  logic [DATA_W-1:0] rf_data_i,
   output logic [31:0]       dm_addr_o,
   input  logic [DATA_W-1:0] dm_data_i,
   output logic              dout_valid_o,
   input  logic              dout_ready_i,
   output logic [DATA_W-1:0] dout_data_o,
   output logic [7:0]        dout_tag_o,
   output logic              dout_last_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REG, ST_MEM, ST_DRAIN} state_t;

   localparam logic [5:0] LAST_REG = 6'(NUM_REGS - 1);
   localparam logic [5:0] LAST_MEM = 6'(NUM_MEM - 1);

   state_t              state_q, state_d;
   logic [5:0]          idx_q, idx_d;
   logic [31:0]         cnt_q;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [7:0]          tag_q, tag_d;
   logic                last_q, last_d;
   logic                load;

   // Output register may take a new word when empty or being emptied this edge.
   assign load = !valid_q || dout_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_q + 32'd1;
         valid_q <= valid_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               data_d  = DATA_W'(cnt_q);
               tag_d   = 8'h00;
               last_d  = 1'b0;
               valid_d = 1'b1;
               idx_d   = '0;
               state_d = ST_REG;
            end
         end
         ST_REG: begin
            if (load) begin
               data_d  = rf_data_i;
               tag_d   = {2'b01, idx_q};
               valid_d = 1'b1;
               if (idx_q == LAST_REG) begin
                  idx_d   = '0;
                  state_d = ST_MEM;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         ST_MEM: begin
            if (load) begin
               data_d  = dm_data_i;
               tag_d   = {2'b10, idx_q};
               valid_d = 1'b1;
               if (idx_q == LAST_MEM) begin
                  last_d  = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         ST_DRAIN: begin
            // valid is always set here, so ready alone marks the final transfer
            if (dout_ready_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read addresses follow the pending index, one word ahead of the output
   // register, so read data is already settled at the load edge.
   assign rf_addr_o    = idx_q[4:0];
   assign dm_addr_o    = MEM_BASE + {24'h0, idx_q, 2'b00};
   assign busy_o       = (state_q != ST_IDLE);
   assign freeze_o     = busy_o;
   assign dout_valid_o = valid_q;
   assign dout_data_o  = data_q;
   assign dout_tag_o   = tag_q;
   assign dout_last_o  = last_q;

endmodule

// File: tb/tb_state_dump_tx.sv
module tb_state_dump_tx;

   localparam logic [31:0] BASE = 32'h100;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  tag;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, freeze;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic        dv;
   logic        dr = 1'b1;
   logic [31:0] dd;
   logic [7:0]  dt;
   logic        dl;

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_pop   = 0;
   logic [31:0] mcnt    = 32'd0;
   logic        rdy_toggle = 1'b0;
   logic [31:0] t_hdr, t_last;
   word_t       sb[$];

   logic        hold_q = 1'b0;
   word_t       hold_w;

   always #5 clk = ~clk;

   state_dump_tx #(
      .DATA_W(32), .NUM_REGS(32), .NUM_MEM(32), .MEM_BASE(BASE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .busy_o(busy), .freeze_o(freeze),
      .rf_addr_o(rf_addr), .rf_data_i(rf_data),
      .dm_addr_o(dm_addr), .dm_data_i(dm_data),
      .dout_valid_o(dv), .dout_ready_i(dr),
      .dout_data_o(dd), .dout_tag_o(dt), .dout_last_o(dl)
   );

   // Memory model: r_k = k, m_i = 0x1000+i at byte address BASE+4*i.
   assign rf_data = {27'h0, rf_addr};
   assign dm_data = (dm_addr >= BASE && dm_addr[1:0] == 2'b00 && dm_addr < BASE + 32'd256)
                    ? 32'h1000 + ((dm_addr - BASE) >> 2) : 32'hDEAD_BEEF;

   // Independent cycle-count model of the header counter.
   always @(posedge clk) begin
      if (rst) mcnt <= 32'd0;
      else     mcnt <= mcnt + 32'd1;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_dump(input logic [31:0] hdr);
      sb.push_back('{data: hdr, tag: 8'h00, last: 1'b0});
      for (int k = 0; k < 32; k++)
         sb.push_back('{data: 32'(k), tag: 8'h40 + 8'(k), last: 1'b0});
      for (int i = 0; i < 32; i++)
         sb.push_back('{data: 32'h1000 + 32'(i), tag: 8'h80 + 8'(i), last: (i == 31)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         tick();
         n++;
      end
      if (sb.size() != 0) check_eq("timeout_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_pops(input int target, input int max);
      int n = 0;
      while (n_pop < target && n < max) begin
         tick();
         n++;
      end
      if (n_pop < target) check_eq("timeout_pops", 64'(n_pop), 64'(target));
   endtask

   task automatic do_start();
      start = 1'b1;
      push_dump(mcnt);
      tick();
      start = 1'b0;
   endtask

   // Ready driver: held high or toggled every cycle.
   initial begin
      forever begin
         tick();
         if (rdy_toggle) dr = ~dr;
         else            dr = 1'b1;
      end
   end

   // Monitor: sampled at negedge, the handshake seen here is what the next edge does.
   always @(negedge clk) begin
      if (rst) begin
         hold_q = 1'b0;
      end else begin
         check_eq("freeze_eq_busy", 64'(freeze), 64'(busy));
         if (dv) check_eq("busy_when_valid", 64'(busy), 64'd1);
         if (hold_q) begin
            check_eq("hold_valid", 64'(dv), 64'd1);
            check_eq("hold_word", 64'({dd, dt, dl}), 64'(hold_w));
         end
         hold_q = dv && !dr;
         hold_w = '{data: dd, tag: dt, last: dl};
         if (dv && dr) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_word", 64'({dd, dt}), 64'hFFFF_FFFF_FFFF);
            end else begin
               word_t w;
               w = sb.pop_front();
               check_eq("data", 64'(dd), 64'(w.data));
               check_eq("tag", 64'(dt), 64'(w.tag));
               check_eq("last", 64'(dl), 64'(w.last));
               if (dt == 8'h00) t_hdr = mcnt;
               if (dl) t_last = mcnt;
               n_pop++;
            end
         end
      end
   end

   initial begin
      repeat (3) tick();
      // reset state
      check_eq("rst_valid", 64'(dv), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_freeze", 64'(freeze), 64'd0);
      check_eq("rst_rf_addr", 64'(rf_addr), 64'd0);
      check_eq("rst_dm_addr", 64'(dm_addr), 64'(BASE));
      check_eq("rst_data", 64'(dd), 64'd0);
      check_eq("rst_tag", 64'(dt), 64'd0);
      check_eq("rst_last", 64'(dl), 64'd0);
      rst = 1'b0;

      // 1: full dump with ready held high, header at counter 10
      while (mcnt != 32'd10) tick();
      start = 1'b1;
      push_dump(32'd10);
      tick();
      start = 1'b0;
      wait_empty(200);
      check_eq("t1_consecutive", 64'(t_last - t_hdr), 64'd64);
      check_eq("t1_busy_after", 64'(busy), 64'd0);
      check_eq("t1_valid_after", 64'(dv), 64'd0);

      // 2: ready toggling
      rdy_toggle = 1'b1;
      repeat (3) tick();
      do_start();
      wait_empty(400);
      rdy_toggle = 1'b0;
      repeat (2) tick();
      check_eq("t2_busy_after", 64'(busy), 64'd0);

      // 3: start pulses during a dump are ignored
      n_pop = 0;
      do_start();
      wait_pops(3, 100);
      start = 1'b1; tick(); start = 1'b0;
      wait_pops(40, 100);
      start = 1'b1; tick(); start = 1'b0;
      wait_empty(200);
      repeat (5) tick();
      check_eq("t3_pops", 64'(n_pop), 64'd65);
      check_eq("t3_busy_after", 64'(busy), 64'd0);

      // 4: reset after 20 transfers, then a fresh dump from counter 0
      n_pop = 0;
      do_start();
      wait_pops(20, 100);
      rst = 1'b1;
      sb.delete();
      tick();
      check_eq("t4_valid", 64'(dv), 64'd0);
      check_eq("t4_busy", 64'(busy), 64'd0);
      check_eq("t4_rf_addr", 64'(rf_addr), 64'd0);
      check_eq("t4_dm_addr", 64'(dm_addr), 64'(BASE));
      check_eq("t4_last", 64'(dl), 64'd0);
      rst = 1'b0;
      start = 1'b1;
      push_dump(32'd0);
      tick();
      start = 1'b0;
      wait_empty(200);

      // 5: start held high, back-to-back dumps 66 cycles apart
      repeat (3) tick();
      n_pop = 0;
      start = 1'b1;
      push_dump(mcnt);
      push_dump(mcnt + 32'd66);
      wait_pops(66, 200);
      start = 1'b0;
      wait_empty(200);
      repeat (3) tick();
      check_eq("t5_pops", 64'(n_pop), 64'd130);
      check_eq("t5_busy_after", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
